quad_decoder8b: RTL

Quadrature decoder that reads a two-phase incremental encoder (channels `a`, `b`) and maintains an 8-bit wrapping position count. It is the input-side counterpart of the up/down counter: the decoder derives direction from the phase order and steps the count itself. It sits between board pins and any logic that consumes position, and provides a per-step pulse and a direction flag.

---
 rtl/quad_decoder8b_pkg.sv | 24 ++
 rtl/quad_decoder8b_sync_ff.sv | 23 ++
 rtl/quad_decoder8b.sv | 122 ++++++++++++
 3 files changed

// File: rtl/quad_decoder8b_pkg.sv
// Shared types and phase helpers for the quadrature decoder.
package qdec_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam logic [1:0] PH0 = 2'b00;
  localparam logic [1:0] PH1 = 2'b01;
  localparam logic [1:0] PH2 = 2'b11;
  localparam logic [1:0] PH3 = 2'b10;

  // Forward successor in the Gray sequence 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    case (ph)
      PH0:     return PH1;
      PH1:     return PH2;
      PH2:     return PH3;
      default: return PH0;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder8b_sync_ff.sv
// One-bit multi-stage synchronizer with synchronous reset.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/quad_decoder8b.sv
// x4 quadrature decoder with wrapping position counter.
// Optional sticky illegal-transition flag enabled by `define QDEC_ERR_EN.
module quad_decoder8b
  import qdec_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int unsigned CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SYNC_STAGES);

  logic             as, bs;
  logic [1:0]       ph;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       prev_q, prev_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d_i (a),
    .q_o (as)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d_i (b),
    .q_o (bs)
  );

  assign ph = {as, bs};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      prev_q  <= PH0;
      q_q     <= '0;
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      q_q     <= q_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    q_d     = q_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    case (state_q)
      INIT: begin
        // Let the synchronizers fill before taking the first phase as reference.
        if (cnt_q == CNT_LAST) begin
          prev_d  = ph;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        prev_d = ph;
        if (ph == next_phase(prev_q)) begin
          q_d    = q_q + 1'b1;
          dir_d  = 1'b1;
          step_d = 1'b1;
        end else if (prev_q == next_phase(ph)) begin
          q_d    = q_q - 1'b1;
          dir_d  = 1'b0;
          step_d = 1'b1;
        end
      end
    endcase
  end

`ifdef QDEC_ERR_EN
  logic illegal;
  logic err_q;

  always_comb begin
    illegal = (state_q == RUN) && ((ph ^ prev_q) == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (illegal) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign q    = q_q;
  assign dir  = dir_q;
  assign step = step_q;

endmodule
